addsub_share_arbiter: RTL
=========================

Name: addsub_share_arbiter

Overview:
- Time-shares one WIDTH-bit add/subtract unit among NREQ requesters using round-robin arbitration.
- Each requester presents an operation (add or subtract) and two operands, then receives a grant and, one cycle later, a registered result.
- Sits between several client blocks and the single ice40 carry-chain adder. Only one adder is mapped regardless of NREQ.

Parameters:
- WIDTH, 9, operand/result width in bits (unsigned)
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- req  input  NREQ  request per requester; held high until its gnt bit is seen
- op  input  NREQ  per-requester operation; 0 = add, 1 = subtract (a - b)
- a_flat  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- b_flat  input  NREQ*WIDTH  operand B; same packing as a_flat
- gnt  output  NREQ  one-hot, single-cycle grant; operands were latched at the same edge
- done  output  NREQ  one-hot, single-cycle result-valid strobe
- result  output  WIDTH  result of the last completed operation; holds until the next done
- carry  output  1  add: carry-out; subtract: borrow (1 iff a < b); holds with result
- busy  output  1  high while an operation is in flight (state EXEC)

Behaviour:
- Reset:
  - sampled on a clk rising edge while rst = 1;
  - gnt, done, result, carry, busy all 0; state IDLE; round-robin pointer last = NREQ-1, so requester 0 has top priority first;
  - rst overrides every other input at that edge.
- State IDLE:
  - at each edge, if any req bit is 1, select the first set bit searching last+1, last+2, ... modulo NREQ;
  - latch that requester's a, b and op into internal registers; set gnt[sel] = 1; set last = sel; set busy = 1; go to EXEC;
  - if no req bit is set, stay in IDLE with all strobes 0.
- State EXEC:
  - at the next edge, compute the latched operation;
  - add: {carry, result} = a + b, i.e. (WIDTH+1)-bit sum;
  - subtract: result = (a - b) mod 2^WIDTH, carry = (a < b);
  - set done[sel] = 1, gnt = 0, busy = 0; return to IDLE;
  - req is ignored during EXEC.
- Latency and throughput:
  - req sampled at edge E0 → gnt high in cycle E0..E1 → done and result valid in cycle E1..E2;
  - maximum throughput is one operation per 2 cycles.
- Requester rules:
  - req must drop in the cycle gnt is seen (that is, before E2);
  - req still high at E2 counts as a new request and is arbitrated normally;
  - operands and op need only be stable at the arbitration edge.
- gnt and done are never high for the same index in the same cycle. At most one bit of each is set.
- result and carry change only on a done edge or on reset.
- Fairness:
  - pointer-based round robin: a continuously asserting requester waits at most NREQ-1 other operations;
  - a newly granted requester becomes lowest priority.
- Reset during EXEC: the operation is discarded, no done is issued, and outputs go to reset values at that edge.
- Other boundary cases:
  - simultaneous requests are resolved only by the pointer;
  - an unused requester with req = 0 is never granted;
  - arithmetic wraps modulo 2^WIDTH, with no saturation.
- Single clock domain, no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then req = 0001, op = 0, a0 = 5, b0 = 7 → gnt = 0001 one cycle after the sampling edge; next cycle done = 0001, result = 12, carry = 0; busy high for exactly one cycle.
- Add overflow: requester 1 with a = 500, b = 20 (WIDTH = 9) → result = 8, carry = 1. Subtract underflow: requester 1 with a = 3, b = 5 → result = 510, carry = 1.
- All four requests held from reset, each dropping its req after its own gnt → grant order 0, 1, 2, 3 on every second cycle. Results match a_i ± b_i for each index.
- req0 and req2 held permanently high → grants alternate 0, 2, 0, 2, ...; requester 1 asserting mid-stream is granted before 0 repeats.
- rst pulsed for one cycle while busy = 1 → no done for the in-flight index; result = 0, carry = 0, gnt = 0. The next request with all four requesters active is granted to requester 0.
- Randomised 10000-cycle run with random req/op/operands against a reference model. Requires:
  - result/carry exact on every done;
  - one-hot gnt and done;
  - no grant while busy;
  - no starvation beyond NREQ-1 intervening operations.

Source files
------------

// File: rtl/addsub_share_arbiter.sv
// Round-robin share of one WIDTH-bit add/subtract unit among NREQ requesters.
// Latency: gnt one cycle after the arbitration edge, done/result one cycle later; req ignored while busy.
module addsub_share_arbiter #(
  parameter int WIDTH = 9,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op,
  input  logic [NREQ*WIDTH-1:0]   a_flat,
  input  logic [NREQ*WIDTH-1:0]   b_flat,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    carry,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  int                cand;

  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH:0]    sum;

  // Search starts just after the last winner, so the winner drops to lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  // Subtract as a + ~b + 1 so a single carry chain serves both operations;
  // the chain's carry-out is then the inverse of the borrow.
  assign b_eff = op_q ? ~b_q : b_q;
  assign sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_q};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          a_d            = a_flat[int'(sel_idx)*WIDTH +: WIDTH];
          b_d            = b_flat[int'(sel_idx)*WIDTH +: WIDTH];
          op_d           = op[sel_idx];
          gnt_d[sel_idx] = 1'b1;
          last_d         = sel_idx;
          busy_d         = 1'b1;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        done_d[last_q] = 1'b1;
        result_d       = sum[WIDTH-1:0];
        carry_d        = op_q ? ~sum[WIDTH] : sum[WIDTH];
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= IW'(NREQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign busy   = busy_q;

endmodule
